// File: rtl/uart_pkg.sv
// Shared UART types and widths for the receiver and transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module bit_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with oversampled mid-bit sampling and a one-entry
// valid/ready holding register; flags framing errors and overruns.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stick,
    input  logic                      rx_in,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      rx_busy,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]      BIT_LAST = 3'(UART_DATA_BITS - 1);

    rx_state_t                 state;
    logic [OS_W-1:0]           os_cnt;
    logic [2:0]                bit_cnt;
    logic [UART_DATA_BITS-1:0] shift;
    logic                      stick_prev;
    logic                      rx_s;
    logic                      tick;
    logic                      stop_sample;

    bit_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_in),
        .q     (rx_s)
    );

    always_comb begin
        tick        = stick && !stick_prev;
        stop_sample = tick && (state == STOP) && (os_cnt == OS_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            stick_prev <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_busy    <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            stick_prev <= stick;
            rx_busy    <= (state != IDLE);
            frame_err  <= 1'b0;
            overrun    <= 1'b0;

            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state  <= START;
                            os_cnt <= '0;
                        end
                    end
                    START: begin
                        if (os_cnt == OS_HALF) begin
                            if (!rx_s) begin
                                state   <= DATA;
                                os_cnt  <= '0;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (os_cnt == OS_LAST) begin
                            shift  <= {rx_s, shift[UART_DATA_BITS-1:1]};
                            os_cnt <= '0;
                            if (bit_cnt == BIT_LAST) state <= STOP;
                            else                     bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        // Stop sampled at mid-bit so back-to-back frames keep margin.
                        if (os_cnt == OS_LAST) begin
                            state     <= IDLE;
                            os_cnt    <= '0;
                            frame_err <= !rx_s;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end

            if (stop_sample && rx_s) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver, companion to the team's `uart_tx` transmitter. It recovers bytes from the serial line using a 16x oversampling tick and validates the start bit at mid-bit. Each received byte is presented on a one-entry valid/ready holding register. It flags framing errors and overruns and sits between the board RX pin and the byte-stream consumer.

## Interface
- `OVERSAMPLE`, default 16: tick edges per bit period; even, ≥4.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low.
- `stick`  in  1  oversample tick, level signal; only rising edges count, detected internally against a registered copy.
- `rx_in`  in  1  serial line, asynchronous, idle high.
- `rx_data`  out  8  received byte; stable while `rx_valid`=1.
- `rx_valid`  out  1  byte available.
- `rx_ready`  in  1  consumer accepts; transfer occurs when `rx_valid`&&`rx_ready` on a clk edge.
- `rx_busy`  out  1  registered (state != IDLE).
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: completed byte dropped because the holding register was full.

## Operation
- `rx_in` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. All sampling uses `rx_s`.
- `tick` = `stick` && !`stick_prev`. FSM advances only on cycles where `tick`=1.
- Counters: `os_cnt`, width $clog2(OVERSAMPLE), wraps to 0 on load; `bit_cnt` is 3 bits.
- IDLE: on a tick with `rx_s`=0, go to START with `os_cnt`=0.
- START: on a tick, `os_cnt`++. When `os_cnt`==OVERSAMPLE/2-1:
  - `rx_s`=0: go to DATA, `os_cnt`=0, `bit_cnt`=0.
  - `rx_s`=1: false start; go to IDLE with no flags raised.
- DATA: on a tick, `os_cnt`++. When `os_cnt`==OVERSAMPLE-1: `shift` = {`rx_s`, `shift`[7:1]} (LSB first) and `os_cnt`=0. After the sample taken with `bit_cnt`==7, go to STOP; otherwise `bit_cnt`++.
- STOP: on a tick, `os_cnt`++. When `os_cnt`==OVERSAMPLE-1, sample and go to IDLE:
  - `rx_s`=1: deliver `shift`.
  - `rx_s`=0: pulse `frame_err` and discard `shift`.
  - A line held low re-enters START from IDLE on the next tick. A break therefore repeats `frame_err` once per frame time.
- Delivery, evaluated in the same cycle:
  - If `rx_valid`=0, or `rx_valid`&&`rx_ready`: load `rx_data` and set `rx_valid`=1; no overrun.
  - Otherwise: pulse `overrun`; the new byte is dropped and the old `rx_data`/`rx_valid` are kept.
- With no delivery, `rx_valid`&&`rx_ready` clears `rx_valid`. `rx_data` holds its last value.
- Frame errors and overruns do not affect the holding register.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0. FSM=IDLE, counters=0, `stick_prev`=0, synchronizer=1.
- Reset mid-frame aborts the frame and discards partial data. The first start detection after reset needs a fresh falling edge sampled on a tick.
- Input latency: `rx_in`→`rx_s` is 2 clk.
- Output latency: `rx_valid`, `frame_err` and `overrun` assert on the clk edge following the tick cycle that samples the stop bit.
- `rx_busy` lags the state by 1 clk.
- Frame length from start detection to stop sample is OVERSAMPLE/2 + 9·OVERSAMPLE ticks; the stop is sampled at mid-bit.
- Back-to-back frames are supported: IDLE is re-entered half a stop bit early, leaving margin for ±2% baud mismatch.
- Consumer handshake: `rx_ready` may be held constantly high; single-cycle acceptance is allowed.

## Structure
- Package `uart_pkg`: `rx_state_t` enum {IDLE, START, DATA, STOP} and localparam `UART_DATA_BITS`=8. The TX state enum and the shared data width move there too.
- Sub-module `bit_sync`: a 2-flop synchronizer with parameterised reset value, reusable for other asynchronous pins.
- Edge detect and FSM stay in `uart_rx`.

## Test plan
All scenarios use OVERSAMPLE=16, `stick` rising every 4 clk (1 bit = 64 clk), and `rx_ready`=1 unless stated.
- Send 0xA5 in 8N1 → `rx_data`=0xA5, `rx_valid` high for 1 cycle, `frame_err`=0.
- Glitch: `rx_in` low for 20 clk (<½ bit), then high → no `rx_valid`, no `frame_err`; `rx_busy` returns to 0.
- Send 0x3C with the stop bit driven low → `frame_err` pulses once, `rx_valid` stays 0, `rx_data` unchanged.
- Hold `rx_ready`=0 and send 0x11 then 0x22 → `rx_data`=0x11 held, `overrun` pulses at the end of the second frame. Then raise `rx_ready` → 0x11 consumed, `rx_valid`=0.
- Send 0x00, 0xFF, 0x55 back-to-back with 1 stop bit each → all three delivered in order, no flags.
- Assert reset mid-DATA of 0x81 → all outputs at reset values; then send 0x7E → 0x7E received correctly.
